// File: rtl/bdf_prog_sequencer.sv
// Host-programmable control sequencer for bdf: streams a stored code-word program,
// then runs start/stop windows. Optional checksum: define BDF_PROG_SEQ_CKSUM_EN.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | waiting for go; store writable
// S_LOAD  | streaming store[0..len-1] with load_ctrl high
// S_GAP   | one settle cycle, last word held on ctrl_out
// S_RUN   | start_ctrl high for RUN_CYCLES
// S_DRAIN | stop_ctrl high for DRAIN_CYCLES
// S_DONE  | one-cycle done pulse
module bdf_prog_sequencer #(
  parameter int CTRL_WIDTH   = 8,
  parameter int PROG_DEPTH   = 16,
  parameter int RUN_CYCLES   = 1000,
  parameter int DRAIN_CYCLES = 1000,
  localparam int AW = $clog2(PROG_DEPTH),
  localparam int LW = $clog2(PROG_DEPTH + 1)
) (
  input  logic                  clk2,
  input  logic                  rst2_n,
  input  logic                  prog_we,
  input  logic [AW-1:0]         prog_addr,
  input  logic [CTRL_WIDTH-1:0] prog_data,
  input  logic [LW-1:0]         prog_len,
  input  logic                  go,
  input  logic                  abort,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic                  load_ctrl,
  output logic                  start_ctrl,
  output logic                  stop_ctrl,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CTRL_WIDTH-1:0] cksum
);

  localparam int TMAX = (RUN_CYCLES > DRAIN_CYCLES) ? RUN_CYCLES : DRAIN_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t                state;
  logic [CTRL_WIDTH-1:0] store [PROG_DEPTH];
  logic [LW-1:0]         addr;
  logic [LW-1:0]         len_q;
  logic [TW-1:0]         tmr;
  logic [AW-1:0]         rd_idx;
  logic [CTRL_WIDTH-1:0] rd_word;
  logic                  go_ok;
  logic                  load_adv;

  always_comb begin
    go_ok    = go && (prog_len != '0) && (int'(prog_len) <= PROG_DEPTH);
    load_adv = (state == S_LOAD) && !abort && (addr != len_q);
    rd_idx   = (state == S_IDLE) ? '0 : addr[AW-1:0];
    rd_word  = store[rd_idx];
    // a write to word 0 in the go cycle must be what LOAD streams first
    if (state == S_IDLE && prog_we && prog_addr == '0)
      rd_word = prog_data;
  end

  always_ff @(posedge clk2) begin
    if (prog_we && state == S_IDLE && int'(prog_addr) < PROG_DEPTH)
      store[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk2 or negedge rst2_n) begin
    if (!rst2_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      len_q      <= '0;
      tmr        <= '0;
      ctrl_out   <= '0;
      load_ctrl  <= 1'b0;
      start_ctrl <= 1'b0;
      stop_ctrl  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go_ok) begin
            state     <= S_LOAD;
            len_q     <= prog_len;
            ctrl_out  <= rd_word;
            load_ctrl <= 1'b1;
            addr      <= LW'(1);
            busy      <= 1'b1;
          end else if (go) begin
            err <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state     <= S_IDLE;
            load_ctrl <= 1'b0;
            ctrl_out  <= '0;
            busy      <= 1'b0;
            err       <= 1'b1;
          end else if (load_adv) begin
            ctrl_out <= rd_word;
            addr     <= addr + LW'(1);
          end else begin
            state     <= S_GAP;
            load_ctrl <= 1'b0;
          end
        end
        S_GAP: begin
          if (abort) begin
            state    <= S_IDLE;
            ctrl_out <= '0;
            busy     <= 1'b0;
            err      <= 1'b1;
          end else begin
            state      <= S_RUN;
            start_ctrl <= 1'b1;
            tmr        <= TW'(RUN_CYCLES - 1);
          end
        end
        S_RUN: begin
          // abort cuts the run short but still gets a full drain window
          if (abort || tmr == '0) begin
            state      <= S_DRAIN;
            start_ctrl <= 1'b0;
            stop_ctrl  <= 1'b1;
            tmr        <= TW'(DRAIN_CYCLES - 1);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_DRAIN: begin
          if (tmr == '0) begin
            state     <= S_DONE;
            stop_ctrl <= 1'b0;
            done      <= 1'b1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          ctrl_out <= '0;
          busy     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BDF_PROG_SEQ_CKSUM_EN
  always_ff @(posedge clk2 or negedge rst2_n) begin
    if (!rst2_n)
      cksum <= '0;
    else if (state == S_IDLE && go_ok)
      cksum <= rd_word;
    else if (load_adv)
      cksum <= cksum ^ rd_word;
  end
`else
  assign cksum = '0;
`endif

endmodule
